xor_cipher_cfg_loader: RTL

Host-side master for the stream cipher's serial configuration chain (cfg_en/cfg_i/cfg_o). It accepts a full parallel key/seed image over a valid/ready handshake and shifts it MSB-first into the cipher's config chain. While shifting, it captures the bits shifted out of the chain and returns the previous chain contents as a parallel word. It shares clk and rst with the cipher.

---
 rtl/xor_cipher_pkg.sv | 14 +
 rtl/cfg_shift_reg.sv | 38 +++
 rtl/xor_cipher_cfg_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared types and constants for the stream cipher configuration loader.
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned CHAIN_W_DEFAULT = 64;
    localparam int unsigned LFSR_W          = 32;

endpackage

// File: rtl/cfg_shift_reg.sv
// Parallel-load / serial-shift register used both to transmit the chain image
// and to capture the bits returning from the chain.
module cfg_shift_reg #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic         ser_o,
    output logic [W-1:0] par_o
);

    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], ser_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_o = sr_q[W-1];
    assign par_o = sr_q;

endmodule

// File: rtl/xor_cipher_cfg_loader.sv
// Host-side master for the cipher serial config chain: shifts a parallel image
// in MSB-first and returns the prior chain contents. Optional readback check: CFG_VERIFY_EN.
module xor_cipher_cfg_loader
    import xor_cipher_pkg::*;
#(
    parameter int unsigned CHAIN_W = CHAIN_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [CHAIN_W-1:0] load_data,
    output logic [CHAIN_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               cfg_en,
    output logic               cfg_i,
    input  logic               cfg_o,
    output logic               cfg_err
);

    localparam int unsigned        CNT_W = $clog2(CHAIN_W);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CHAIN_W - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_load, tx_shift, cap_shift;
    logic               tx_msb, tx_ser_in;
    logic               cap_ser_unused;
    logic [CHAIN_W-1:0] tx_par_unused;

    // With verification the TX register rotates, so after the SHIFT pass it
    // again holds the image and can be compared bit-for-bit during VERIFY.
`ifdef CFG_VERIFY_EN
    logic err_q, err_d;
    assign tx_ser_in = tx_msb;
`else
    assign tx_ser_in = 1'b0;
`endif

    cfg_shift_reg #(.W(CHAIN_W)) u_txsr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (tx_load),
        .load_data_i (load_data),
        .shift_i     (tx_shift),
        .ser_i       (tx_ser_in),
        .ser_o       (tx_msb),
        .par_o       (tx_par_unused)
    );

    cfg_shift_reg #(.W(CHAIN_W)) u_capture (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (cap_shift),
        .ser_i       (cfg_o),
        .ser_o       (cap_ser_unused),
        .par_o       (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        cap_shift = 1'b0;
`ifdef CFG_VERIFY_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    tx_load = 1'b1;
`ifdef CFG_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                tx_shift  = 1'b1;
                cap_shift = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef CFG_VERIFY_EN
                    state_d = VERIFY;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CFG_VERIFY_EN
            VERIFY: begin
                tx_shift = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cfg_o != tx_msb) begin
                    err_d = 1'b1;
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CFG_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;
    // Recirculate the chain tail so the chain contents survive the readback pass.
    assign cfg_i   = (state_q == SHIFT)  ? tx_msb :
                     (state_q == VERIFY) ? cfg_o  : 1'b0;
    assign cfg_en  = (state_q == SHIFT) || (state_q == VERIFY);
`else
    assign cfg_err = 1'b0;
    assign cfg_i   = (state_q == SHIFT) ? tx_msb : 1'b0;
    assign cfg_en  = (state_q == SHIFT);
`endif

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rd_valid   = (state_q == DONE);

endmodule
